// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, one-cycle RAM access, held response.
// Optional misaligned-access trapping is built when LSU_MISALIGN_TRAP_EN is defined.
`timescale 1ns/1ps
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_address,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [1:0]            mem_data_size,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  logic [31:0]           mem_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_next;
  logic                  lat_write;
  logic [2:0]            lat_funct3;
  logic [ADDR_WIDTH-1:0] lat_address;
  logic [31:0]           lat_wdata;
  logic [31:0]           rdata_q;
  logic                  error_q;
  logic                  misalign;
  logic                  illegal;
  logic [31:0]           load_data;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_funct3[1:0] == 2'b01) && req_address[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_write && req_funct3[2]) ||
                   (req_address[31:ADDR_WIDTH] != '0) || misalign;

  always_comb begin
    load_data = mem_data;
    case (lat_funct3)
      3'b000:  load_data = {{24{mem_data[7]}}, mem_data[7:0]};
      3'b001:  load_data = {{16{mem_data[15]}}, mem_data[15:0]};
      3'b100:  load_data = {24'h0, mem_data[7:0]};
      3'b101:  load_data = {16'h0, mem_data[15:0]};
      default: load_data = mem_data;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_write   <= 1'b0;
      lat_funct3  <= '0;
      lat_address <= '0;
      lat_wdata   <= '0;
      rdata_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (req_valid) begin
          lat_write   <= req_write;
          lat_funct3  <= req_funct3;
          lat_address <= req_address[ADDR_WIDTH-1:0];
          lat_wdata   <= req_wdata;
          rdata_q     <= '0;
          error_q     <= illegal;
        end
        ACCESS: if (!lat_write) rdata_q <= load_data;
        RESP: if (resp_ready) begin
          rdata_q <= '0;
          error_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Strobes decode purely from state so an async reset drops them immediately.
  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    mem_data_size = 2'b00;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_write     = lat_write;
        mem_read      = !lat_write;
        mem_data_size = (lat_funct3[1:0] == 2'b00) ? 2'b00 :
                        (lat_funct3[1:0] == 2'b01) ? 2'b01 : 2'b11;
        state_next    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign resp_rdata  = rdata_q;
  assign resp_error  = error_q;
  assign mem_address = lat_address;
  assign mem_data    = mem_write ? lat_wdata : 'z;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory access controller between the core's execute stage and the byte-addressed `ram` block. It accepts one load or store request at a time over a valid/ready handshake and drives the RAM's `write`/`read`/`data_size`/`address` strobes and the shared tristate `data` bus. It returns sign- or zero-extended load data, or a store completion, over a response handshake. Illegal requests are rejected with an error response and never reach the RAM.

## Interface
- `ADDR_WIDTH`, 16, RAM address width; must match the RAM instance.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_address`  in  32  byte address.
- `req_wdata`  in  32  store data, taken from the low bytes.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `resp_error`  out  1  request rejected.
- `mem_write`  out  1  to RAM `write`.
- `mem_read`  out  1  to RAM `read`.
- `mem_data_size`  out  2  to RAM `data_size`: 00 byte, 01 half, 11 word.
- `mem_address`  out  ADDR_WIDTH  to RAM `address`.
- `mem_data`  inout  32  shared bus to RAM `data`.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE
  - `req_ready` = 1.
  - On `req_valid`, latch write, funct3, address and wdata.
  - Legal request: go to ACCESS.
  - Illegal request: set error and go directly to RESP.
- Illegal request, any of:
  - funct3 011, 110 or 111.
  - Store with funct3 bit 2 set.
  - `req_address[31:ADDR_WIDTH]` nonzero.
  - Misaligned access, when enabled (see Configuration).
- ACCESS lasts exactly one cycle, then the unit goes to RESP.
  - Store: `mem_write`=1, `mem_data` driven with the latched wdata, `mem_data_size` from funct3[1:0] (00→00, 01→01, 10→11). The RAM commits at the closing edge.
  - Load: `mem_read`=1 and `mem_write`=0. `mem_data` is captured at the closing edge.
    - LB/LBU: byte [7:0], sign- or zero-extended.
    - LH/LHU: half [15:0], sign- or zero-extended.
    - LW: all 32 bits.
- RESP: `resp_valid`=1 with `resp_rdata` and `resp_error` held stable until `resp_ready`. On `resp_valid && resp_ready`, return to IDLE.
- `req_ready`=0 in ACCESS and RESP. At most one request is outstanding.
- `mem_address` = latched address[ADDR_WIDTH-1:0]. Accesses at the top of memory wrap as the RAM does; the unit applies no extra check.
- Tristate rule:
  - `mem_data` is driven only in ACCESS with a store; it is `'z` otherwise.
  - `mem_read` and `mem_write` are never both 1.
  - Strobes are 0 outside ACCESS.

## Timing
- Request handshake at edge N: ACCESS occupies cycle N+1; `resp_valid` rises after edge N+1.
- Error path: `resp_valid` rises after edge N, with no RAM access.
- Best-case throughput: one request per 3 cycles (IDLE, ACCESS, RESP) when `resp_ready` is held high.
- Reset values, applied asynchronously:
  - State IDLE.
  - `req_ready`=1; `resp_valid`=0, `resp_error`=0, `resp_rdata`=0.
  - `mem_write`=0, `mem_read`=0, `mem_data_size`=00, `mem_address`=0.
  - `mem_data`=`'z`.
- Reset asserted during ACCESS drops strobes immediately. A store is guaranteed not to commit only if reset is asserted before the closing edge.
- Reset during RESP discards the response.
- Request inputs are ignored outside IDLE.
- `resp_ready` is ignored outside RESP.
- `resp_*` hold stable while `resp_valid && !resp_ready`.

## Configuration
- `LSU_MISALIGN_TRAP_EN`
  - Defined: a halfword with address[0]≠0, or a word with address[1:0]≠0, is illegal and gets an error response with no RAM access.
  - Undefined: misaligned accesses pass through unchanged, since the RAM supports byte-granular addresses; `resp_error` only reflects funct3 and range errors.

## Test plan
- SW 0xDEADBEEF @0x0010, then LW @0x0010 → store response with `resp_error`=0 and `resp_rdata`=0. Load response 0xDEADBEEF, `resp_valid` after edge N+1.
- SB 0x80 @0x0020, then LB @0x0020 → 0xFFFFFF80; LBU @0x0020 → 0x00000080. Neighbouring bytes are unchanged.
- SH 0x8001 @0x0030, then LH → 0xFFFF8001; LHU → 0x00008001. `mem_data_size`=01 during the store ACCESS.
- Error cases, each → `resp_error`=1 after edge N, `mem_read`=`mem_write`=0 throughout:
  - LW @0x00010000 with ADDR_WIDTH=16.
  - funct3=011.
  - Store with funct3=100.
- LW @0x0002 with the macro defined → error. Without the macro → returns bytes 2..5.
- Hold `resp_ready`=0 for 5 cycles → `resp_*` stable and `req_ready`=0. Assert `reset_n`=0 during ACCESS of an SW → strobes drop at once, `mem_data`=`'z`, unit returns to IDLE.
